// File: rtl/usb_boot_pkg.sv
// Shared types and constants for the USB detach / warm-boot hand-off sequencer.
package usb_boot_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DETACH = 3'd1,
    SETUP  = 3'd2,
    FIRE   = 3'd3,
    DONE   = 3'd4
  } boot_state_t;

  localparam logic [1:0] IMG_BOOTLOADER = 2'd0;
  localparam logic [1:0] IMG_USER       = 2'd1;

  localparam int unsigned CLK_FREQ_HZ_DEFAULT = 48_000_000;

  function automatic int unsigned cycles_per_ms(input int unsigned clk_freq_hz);
    return clk_freq_hz / 1000;
  endfunction

  localparam int unsigned CYCLES_PER_MS = cycles_per_ms(CLK_FREQ_HZ_DEFAULT);

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond divider: one-cycle tick each time the counter wraps.
// A synchronous clear restarts the period, so the next tick is a full DIVISOR cycles away.
module ms_tick_gen #(
  parameter int unsigned DIVISOR = usb_boot_pkg::CYCLES_PER_MS
) (
  input  logic clk_48mhz,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // NOTE: non-blocking assignments for every flop, so all registers update from pre-edge values.
  always_ff @(posedge clk_48mhz) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/usb_boot_sequencer.sv
// Turns a bootloader boot request into: USB detach, timed hold, image select setup,
// then a sticky warm-boot trigger. Terminal once fired; only reset restarts it.
module usb_boot_sequencer
  import usb_boot_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = 48_000_000,
  parameter int unsigned DETACH_MS     = 10,
  parameter int unsigned SETUP_CYCLES  = 16,
  parameter logic [1:0]  DEFAULT_IMAGE = IMG_USER
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       boot_req,
  input  logic [1:0] image_sel,
  input  logic       image_sel_valid,
  output logic       usb_pu_en,
  output logic       usb_force_se0,
  output logic       wb_s1,
  output logic       wb_s0,
  output logic       wb_boot,
  output logic       busy
);

  localparam logic [9:0] DETACH_LAST = 10'(DETACH_MS - 1);
  localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYCLES - 1);

  boot_state_t state, state_next;
  logic [9:0]  ms_cnt;
  logic [7:0]  setup_cnt;
  logic [1:0]  img_q;
  logic        ms_tick;
  logic        detach_entry;

  assign detach_entry = (state == IDLE) && (state_next == DETACH);

  ms_tick_gen #(
    .DIVISOR (cycles_per_ms(CLK_FREQ_HZ))
  ) u_ms_tick_gen (
    .clk_48mhz (clk_48mhz),
    .reset     (reset),
    .clear     (detach_entry),
    .tick      (ms_tick)
  );

  // NOTE: next state defaults to the current state first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (boot_req) state_next = DETACH;
      DETACH:  if (ms_tick && (ms_cnt == DETACH_LAST)) state_next = SETUP;
      SETUP:   if (setup_cnt == SETUP_LAST) state_next = FIRE;
      FIRE:    state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state          <= IDLE;
      ms_cnt         <= '0;
      setup_cnt      <= '0;
      img_q          <= DEFAULT_IMAGE;
      usb_pu_en      <= 1'b1;
      usb_force_se0  <= 1'b0;
      {wb_s1, wb_s0} <= DEFAULT_IMAGE;
      wb_boot        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state <= state_next;

      // Outputs are registered from the next state so they move on the same edge as the state.
      usb_pu_en     <= (state_next == IDLE);
      usb_force_se0 <= (state_next != IDLE);
      busy          <= (state_next != IDLE);
      wb_boot       <= wb_boot | (state_next == FIRE);

      if ((state == IDLE) && boot_req) begin
        img_q <= image_sel_valid ? image_sel : DEFAULT_IMAGE;
      end

      if ((state != SETUP) && (state_next == SETUP)) begin
        {wb_s1, wb_s0} <= img_q;
      end

      if (state != DETACH) begin
        ms_cnt <= '0;
      end else if (ms_tick && (ms_cnt != '1)) begin
        ms_cnt <= ms_cnt + 1'b1;
      end

      if (state != SETUP) begin
        setup_cnt <= '0;
      end else if (setup_cnt != '1) begin
        setup_cnt <= setup_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_usb_boot_sequencer.sv
// Directed bench for usb_boot_sequencer at 48 cycles/ms, 3 ms detach, 4 setup cycles.
module tb_usb_boot_sequencer;

  logic       clk_48mhz = 1'b0;
  logic       reset = 1'b1;
  logic       boot_req = 1'b0;
  logic [1:0] image_sel = 2'b00;
  logic       image_sel_valid = 1'b0;
  logic       usb_pu_en, usb_force_se0, wb_s1, wb_s0, wb_boot, busy;

  int checks = 0;
  int errors = 0;

  usb_boot_sequencer #(
    .CLK_FREQ_HZ   (48000),
    .DETACH_MS     (3),
    .SETUP_CYCLES  (4),
    .DEFAULT_IMAGE (2'b01)
  ) dut (
    .clk_48mhz       (clk_48mhz),
    .reset           (reset),
    .boot_req        (boot_req),
    .image_sel       (image_sel),
    .image_sel_valid (image_sel_valid),
    .usb_pu_en       (usb_pu_en),
    .usb_force_se0   (usb_force_se0),
    .wb_s1           (wb_s1),
    .wb_s0           (wb_s0),
    .wb_boot         (wb_boot),
    .busy            (busy)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_48mhz);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic pu, input logic se0,
                               input logic [1:0] img, input logic boot, input logic bsy);
    check({tag, "_pu_en"},     32'(usb_pu_en),        32'(pu));
    check({tag, "_force_se0"}, 32'(usb_force_se0),    32'(se0));
    check({tag, "_s1s0"},      32'({wb_s1, wb_s0}),   32'(img));
    check({tag, "_wb_boot"},   32'(wb_boot),          32'(boot));
    check({tag, "_busy"},      32'(busy),             32'(bsy));
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    boot_req = 1'b0;
    tick(2);
    check_outputs("reset", 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  // Cycle c = c-th edge after boot_req is first sampled high.
  // DETACH spans c=1..144, SETUP c=145..148, FIRE c=149, DONE from c=150.
  task automatic run_sequence(input string tag, input logic [1:0] sel, input logic valid,
                              input logic [1:0] exp_img, input int drop_at);
    image_sel       = sel;
    image_sel_valid = valid;
    boot_req        = 1'b1;
    for (int c = 1; c <= 150; c++) begin
      tick(1);
      if (c == drop_at) boot_req = 1'b0;
      if (c == 2) image_sel = ~sel;
      case (c)
        1:       check_outputs({tag, "_detach_entry"}, 1'b0, 1'b1, 2'b01,   1'b0, 1'b1);
        100:     check_outputs({tag, "_detach_mid"},   1'b0, 1'b1, 2'b01,   1'b0, 1'b1);
        144:     check_outputs({tag, "_detach_last"},  1'b0, 1'b1, 2'b01,   1'b0, 1'b1);
        145:     check_outputs({tag, "_setup_entry"},  1'b0, 1'b1, exp_img, 1'b0, 1'b1);
        148:     check_outputs({tag, "_setup_last"},   1'b0, 1'b1, exp_img, 1'b0, 1'b1);
        149:     check_outputs({tag, "_fire"},         1'b0, 1'b1, exp_img, 1'b1, 1'b1);
        150:     check_outputs({tag, "_done"},         1'b0, 1'b1, exp_img, 1'b1, 1'b1);
        default: ;
      endcase
    end
  endtask

  initial begin
    // Nominal: default image, request held.
    do_reset();
    tick(7);
    check_outputs("idle", 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    run_sequence("nominal", 2'b10, 1'b0, 2'b01, 0);

    // Valid image select with a single-cycle request; image_sel changes during DETACH.
    do_reset();
    run_sequence("imgsel", 2'b11, 1'b1, 2'b11, 1);

    // Request drops mid-DETACH; sequence must not abort.
    do_reset();
    run_sequence("abort", 2'b00, 1'b0, 2'b01, 50);

    // Reset during SETUP, then a full restart.
    do_reset();
    image_sel       = 2'b11;
    image_sel_valid = 1'b1;
    boot_req        = 1'b1;
    tick(146);
    check_outputs("pre_reset_setup", 1'b0, 1'b1, 2'b11, 1'b0, 1'b1);
    reset = 1'b1;
    tick(1);
    check_outputs("mid_reset", 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    reset    = 1'b0;
    boot_req = 1'b0;
    tick(3);
    check_outputs("post_reset_idle", 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    run_sequence("restart", 2'b10, 1'b1, 2'b10, 0);

    // Request held through reset: ignored until the first edge after release.
    reset    = 1'b1;
    boot_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_outputs("req_in_reset", 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    end
    reset = 1'b0;
    run_sequence("req_thru_reset", 2'b00, 1'b0, 2'b01, 0);

    // Terminal state: inputs toggled, outputs frozen.
    for (int i = 0; i < 1000; i++) begin
      boot_req        = 1'($urandom_range(0, 1));
      image_sel       = 2'($urandom_range(0, 3));
      image_sel_valid = 1'($urandom_range(0, 1));
      tick(1);
      check("done_hold", 32'({usb_pu_en, usb_force_se0, wb_s1, wb_s0, wb_boot, busy}),
            32'(6'b010111));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
